// File: rtl/aemb_dwb_io_if.sv
// aemb_dwb_io_if: Wishbone classic dwb bus bundle between the AEMB2 core and its I/O responder.
interface aemb_dwb_io_if #(
    parameter int AW = 18
);
    logic [AW-1:2] adr;
    logic [31:0]   wdat;
    logic [31:0]   rdat;
    logic [3:0]    sel;
    logic          stb;
    logic          cyc;
    logic          wre;
    logic          ack;

    modport master (output adr, wdat, sel, stb, cyc, wre, input rdat, ack);
    modport slave  (input adr, wdat, sel, stb, cyc, wre, output rdat, ack);
endinterface

// File: rtl/aemb_dwb_io.sv
// aemb_dwb_io: dwb responder with on-chip RAM, console byte FIFO and interrupt controller.
// Define AEMB_DWB_IO_TIMER_EN to build the periodic timer and its pending logic.
module aemb_dwb_io #(
    parameter int AW        = 18,
    parameter int RAM_AW    = 12,
    parameter int WAIT      = 0,
    parameter int CON_DEPTH = 16
) (
    input  logic                sys_clk_i,
    input  logic                sys_rst_i,
    aemb_dwb_io_if.slave        dwb,
    output logic [7:0]          con_dat_o,
    output logic                con_stb_o,
    input  logic                con_ack_i,
    output logic                sys_int_o
);
    localparam int         PW     = $clog2(CON_DEPTH);
    localparam logic [1:0] WAIT_N = 2'(WAIT);

    logic              ack;
    logic [1:0]        wcnt;
    logic              rd_io_q;
    logic [31:0]       io_q;
    logic [31:0]       ram_q;
    logic [31:0]       io_rd;
    logic              req;
    logic              commit;
    logic              is_io;
    logic              wr_ram;
    logic              wr_io;
    logic [3:0]        io_idx;
    logic [RAM_AW-1:0] ram_idx;
    logic [3:0]        be;
    logic [31:0]       ram [2**RAM_AW];

    logic [7:0]        fifo [CON_DEPTH];
    logic [PW-1:0]     wp;
    logic [PW-1:0]     rp;
    logic [PW:0]       con_cnt;
    logic              ovf;
    logic              push;
    logic              push_ok;
    logic              pop;
    logic              full;

    logic              en;
    logic              sw;
    logic              pend;
    logic              unused_adr;

    assign req     = dwb.stb & dwb.cyc & ~ack;
    assign commit  = req & (wcnt == WAIT_N) & ~sys_rst_i;
    assign is_io   = dwb.adr[AW-1];
    assign io_idx  = dwb.adr[5:2];
    assign ram_idx = dwb.adr[RAM_AW+1:2];
    assign wr_ram  = commit & dwb.wre & ~is_io;
    assign wr_io   = commit & dwb.wre & is_io;
    assign unused_adr = ^dwb.adr[AW-2:RAM_AW+2];

    assign dwb.ack  = ack;
    assign dwb.rdat = ack ? (rd_io_q ? io_q : ram_q) : '0;

    // Only single-byte, aligned half-word and full-word lane patterns write.
    always_comb begin
        be = '0;
        case (dwb.sel)
            4'h1, 4'h2, 4'h4, 4'h8, 4'h3, 4'hC, 4'hF: be = dwb.sel;
            default: be = '0;
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (wr_ram) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) ram[ram_idx][8*i +: 8] <= dwb.wdat[8*i +: 8];
            end
        end
        if (commit & ~dwb.wre & ~is_io) ram_q <= ram[ram_idx];
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            ack     <= 1'b0;
            wcnt    <= '0;
            rd_io_q <= 1'b0;
            io_q    <= '0;
        end else begin
            ack <= commit;
            if (commit || !req) wcnt <= '0;
            else                wcnt <= wcnt + 2'd1;
            if (commit) begin
                rd_io_q <= is_io;
                io_q    <= io_rd;
            end
        end
    end

    assign push      = wr_io & (io_idx == 4'd0);
    assign full      = con_cnt == (PW+1)'(CON_DEPTH);
    assign con_stb_o = con_cnt != '0;
    assign pop       = con_stb_o & con_ack_i;
    // A pop in the same cycle frees the slot for a push into a full FIFO.
    assign push_ok   = push & (~full | pop);
    assign con_dat_o = con_stb_o ? fifo[rp] : '0;

    always_ff @(posedge sys_clk_i) begin
        if (push_ok) fifo[wp] <= dwb.wdat[31:24];
    end

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            wp      <= '0;
            rp      <= '0;
            con_cnt <= '0;
            ovf     <= 1'b0;
        end else begin
            if (push_ok) wp <= wp + 1'b1;
            if (pop)     rp <= rp + 1'b1;
            con_cnt <= con_cnt + (PW+1)'(push_ok) - (PW+1)'(pop);
            if (wr_io && io_idx == 4'd1) ovf <= 1'b0;
            else if (push && !push_ok)   ovf <= 1'b1;
        end
    end

`ifdef AEMB_DWB_IO_TIMER_EN
    logic [31:0] tmr_cnt;
    logic [31:0] tmr_per;
    logic        tick;

    assign tick = tmr_cnt == tmr_per;

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            tmr_cnt <= '0;
            tmr_per <= 32'd32767;
            pend    <= 1'b0;
        end else begin
            if (wr_io && io_idx == 4'd2) tmr_cnt <= dwb.wdat;
            else if (tick)               tmr_cnt <= '0;
            else                         tmr_cnt <= tmr_cnt + 32'd1;
            if (wr_io && io_idx == 4'd3) tmr_per <= dwb.wdat;
            // A wrap in the same cycle as a write-1-to-clear keeps pending set.
            if (tick)                                      pend <= 1'b1;
            else if (wr_io && io_idx == 4'd8 && dwb.wdat[1]) pend <= 1'b0;
        end
    end
`else
    assign pend = 1'b0;
`endif

    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            en        <= 1'b0;
            sw        <= 1'b0;
            sys_int_o <= 1'b0;
        end else begin
            if (wr_io && io_idx == 4'd8) begin
                en <= dwb.wdat[0];
                sw <= dwb.wdat[2];
            end
            sys_int_o <= (pend & en) | sw;
        end
    end

    always_comb begin
        io_rd = '0;
        case (io_idx)
            4'd1: io_rd = {ovf, 15'b0, 16'(con_cnt)};
`ifdef AEMB_DWB_IO_TIMER_EN
            4'd2: io_rd = tmr_cnt;
            4'd3: io_rd = tmr_per;
`endif
            4'd8: io_rd = {29'b0, sw, pend, en};
            default: io_rd = '0;
        endcase
    end
endmodule

// File: tb/tb_aemb_dwb_io.sv
// tb_aemb_dwb_io: directed scoreboard bench for aemb_dwb_io with WAIT=0 and WAIT=2 instances.
module tb_aemb_dwb_io;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] t_adr = '0;
    logic [31:0] t_wdat = '0;
    logic [3:0]  t_sel = '0;
    logic        t_stb = 1'b0;
    logic        t_wre = 1'b0;
    int          dsel = 0;
    logic        con_ack = 1'b0;
    logic [7:0]  con_dat;
    logic        con_stb;
    logic        sys_int;
    logic [7:0]  d2_con_dat;
    logic        d2_con_stb;
    logic        d2_int;
    logic        ack;
    logic [31:0] rdat;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    int commit_cyc = 0;
    logic int_at_ack = 1'b0;
    logic [31:0] exp_q [$];
    logic [7:0]  con_q [$];

    aemb_dwb_io_if #(.AW(18)) bus0 ();
    aemb_dwb_io_if #(.AW(18)) bus2 ();

    assign bus0.adr = t_adr;  assign bus2.adr = t_adr;
    assign bus0.wdat = t_wdat; assign bus2.wdat = t_wdat;
    assign bus0.sel = t_sel;  assign bus2.sel = t_sel;
    assign bus0.wre = t_wre;  assign bus2.wre = t_wre;
    assign bus0.stb = t_stb & (dsel == 0); assign bus0.cyc = t_stb & (dsel == 0);
    assign bus2.stb = t_stb & (dsel == 1); assign bus2.cyc = t_stb & (dsel == 1);
    assign ack  = (dsel == 1) ? bus2.ack  : bus0.ack;
    assign rdat = (dsel == 1) ? bus2.rdat : bus0.rdat;

    aemb_dwb_io #(.AW(18), .RAM_AW(12), .WAIT(0), .CON_DEPTH(16)) u_dut (
        .sys_clk_i(clk), .sys_rst_i(rst), .dwb(bus0.slave),
        .con_dat_o(con_dat), .con_stb_o(con_stb), .con_ack_i(con_ack), .sys_int_o(sys_int)
    );

    aemb_dwb_io #(.AW(18), .RAM_AW(12), .WAIT(2), .CON_DEPTH(16)) u_dut2 (
        .sys_clk_i(clk), .sys_rst_i(rst), .dwb(bus2.slave),
        .con_dat_o(d2_con_dat), .con_stb_o(d2_con_stb), .con_ack_i(1'b0), .sys_int_o(d2_int)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_n <= cyc_n + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [15:0] io(input int idx);
        return 16'h8000 | 16'(idx);
    endfunction

    // One bus transfer started just after a rising edge; checks ack latency and one-cycle width.
    task automatic xfer(input logic w, input logic [15:0] a, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] q);
        int lat = 0;
        t_adr = a; t_wdat = d; t_sel = s; t_wre = w; t_stb = 1'b1;
        do begin
            @(posedge clk); #1; lat++;
        end while (!ack && lat < 10);
        q = rdat;
        commit_cyc = cyc_n;
        int_at_ack = sys_int;
        check("ack_lat", 32'(lat), (dsel == 1) ? 32'd3 : 32'd1);
        @(posedge clk); #1;
        check("ack_len", {31'b0, ack}, 32'd0);
        t_stb = 1'b0;
    endtask

    task automatic wr(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] q;
        xfer(1'b1, a, d, s, q);
    endtask

    task automatic rd(input logic [15:0] a, input string tag);
        logic [31:0] q;
        logic [31:0] e;
        xfer(1'b0, a, 32'h0, 4'hF, q);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hXXXX_XXXX;
        check(tag, q, e);
    endtask

    task automatic wait_until(input int c);
        int guard = 0;
        while (cyc_n < c && guard < 1000) begin
            @(posedge clk); #1; guard++;
        end
    endtask

    // Console sink: every accepted pop must match the next byte pushed by the stimulus.
    always @(negedge clk) begin
        if (!rst && con_stb && con_ack) begin
            check("con_pop", {24'b0, con_dat}, (con_q.size() != 0) ? {24'b0, con_q.pop_front()} : 32'hFFFF_FFFF);
        end
    end

    initial begin
        logic [31:0] q;
        int t0;
        int guard;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_ack", {31'b0, bus0.ack}, 32'd0);
        check("rst_rdat", bus0.rdat, 32'd0);
        check("rst_con_stb", {31'b0, con_stb}, 32'd0);
        check("rst_con_dat", {24'b0, con_dat}, 32'd0);
        check("rst_int", {31'b0, sys_int}, 32'd0);
        exp_q.push_back(32'h0); rd(io(1), "rst_con_stat");
        exp_q.push_back(32'h0); rd(io(8), "rst_int_reg");

        wr(16'h0010, 32'h11223344, 4'hF);
        exp_q.push_back(32'h11223344); rd(16'h0010, "ram_full");
        wr(16'h0010, 32'hAABBCCDD, 4'h4);
        wr(16'h0010, 32'h0000EEFF, 4'h3);
        exp_q.push_back(32'h11BBEEFF); rd(16'h0010, "ram_lanes");
        wr(16'h0010, 32'hFFFFFFFF, 4'h5);
        exp_q.push_back(32'h11BBEEFF); rd(16'h0010, "ram_sel5");
        exp_q.push_back(32'h11BBEEFF); rd(16'h1010, "ram_alias");
        wr(io(5), 32'h12345678, 4'hF);
        exp_q.push_back(32'h0); rd(io(5), "io_unmapped");

        dsel = 1;
        wr(16'h0020, 32'h12345678, 4'hF);
        t_adr = 16'h0020; t_wdat = 32'h5A5A5A5A; t_sel = 4'hF; t_wre = 1'b1; t_stb = 1'b1;
        @(posedge clk); #1 t_stb = 1'b0;
        repeat (4) @(posedge clk);
        #1 check("abort_ack", {31'b0, bus2.ack}, 32'd0);
        exp_q.push_back(32'h12345678); rd(16'h0020, "abort_ram");
        dsel = 0;

        for (int i = 0; i < 17; i++) begin
            if (i < 16) con_q.push_back(8'(8'h41 + i));
            wr(io(0), {8'(8'h41 + i), 24'h0}, 4'h1);
        end
        exp_q.push_back(32'h80000010); rd(io(1), "con_full_stat");
        exp_q.push_back(32'h0); rd(io(0), "con_read0");
        check("con_head", {24'b0, con_dat}, 32'h41);
        con_ack = 1'b1;
        guard = 0;
        while (con_stb && guard < 40) begin @(posedge clk); #1; guard++; end
        con_ack = 1'b0;
        check("con_drained", 32'(con_q.size()), 32'd0);
        exp_q.push_back(32'h80000000); rd(io(1), "con_ovf_sticky");
        wr(io(1), 32'h0, 4'hF);
        exp_q.push_back(32'h0); rd(io(1), "con_ovf_clear");

        for (int i = 0; i < 16; i++) begin
            con_q.push_back(8'(8'h60 + i));
            wr(io(0), {8'(8'h60 + i), 24'h0}, 4'hF);
        end
        con_q.push_back(8'h70);
        con_ack = 1'b1;
        wr(io(0), 32'h70000000, 4'hF);
        guard = 0;
        while (con_stb && guard < 40) begin @(posedge clk); #1; guard++; end
        con_ack = 1'b0;
        check("con_fullpp_drained", 32'(con_q.size()), 32'd0);
        exp_q.push_back(32'h0); rd(io(1), "con_fullpp_stat");

`ifdef AEMB_DWB_IO_TIMER_EN
        exp_q.push_back(32'd32767); rd(io(3), "tmr_per_rst");
        wr(io(3), 32'd9, 4'hF);
        wr(io(2), 32'd0, 4'hF);
        t0 = commit_cyc;
        wr(io(8), 32'h1, 4'hF);
        wait_until(t0 + 10);
        check("tmr_int_early", {31'b0, sys_int}, 32'd0);
        wait_until(t0 + 11);
        check("tmr_int_rise", {31'b0, sys_int}, 32'd1);
        exp_q.push_back(32'h3); rd(io(8), "tmr_pend");
        exp_q.push_back(32'd9); rd(io(3), "tmr_per");
        wait_until(t0 + 29);
        wr(io(8), 32'h3, 4'hF);
        check("tmr_w1c_cycle", 32'(commit_cyc - t0), 32'd30);
        exp_q.push_back(32'h3); rd(io(8), "tmr_set_wins");
        wr(io(8), 32'h3, 4'hF);
        exp_q.push_back(32'h1); rd(io(8), "tmr_w1c");
`else
        wr(io(3), 32'd9, 4'hF);
        wr(io(2), 32'd5, 4'hF);
        exp_q.push_back(32'h0); rd(io(2), "tmr_cnt_off");
        exp_q.push_back(32'h0); rd(io(3), "tmr_per_off");
        wr(io(8), 32'h1, 4'hF);
        exp_q.push_back(32'h1); rd(io(8), "int_en_rb");
        check("int_no_timer", {31'b0, sys_int}, 32'd0);
`endif

        wr(io(8), 32'h0, 4'hF);
        @(posedge clk); #1;
        check("sw_pre", {31'b0, sys_int}, 32'd0);
        wr(io(8), 32'h4, 4'hF);
        check("sw_at_commit", {31'b0, int_at_ack}, 32'd0);
        check("sw_rise", {31'b0, sys_int}, 32'd1);
        wr(io(8), 32'h0, 4'hF);
        check("sw_fall", {31'b0, sys_int}, 32'd0);

        dsel = 1;
        t_adr = 16'h0020; t_wdat = 32'hDEADBEEF; t_sel = 4'hF; t_wre = 1'b1; t_stb = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_ack", {31'b0, bus2.ack}, 32'd0);
        t_stb = 1'b0; rst = 1'b0;
        exp_q.push_back(32'h12345678); rd(16'h0020, "rst_mid_ram");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
